mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified, variable-latency memory port between the single-cycle core's instruction-fetch path and its load/store path. Each requester uses a hold-until-ready handshake. The arbiter grants one requester at a time, runs a single outstanding memory transaction, and returns a one-cycle ready pulse with read data. It sits between the core (fetch and D-mem ports) and the shared memory model or SRAM wrapper.

## Interface
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width; data is passed through byte-order unchanged

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held high until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held high until d_ready
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- mem_cen  out  1  memory command strobe, one cycle per transaction
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in completion cycle
- mem_stall  in  1  memory busy; completion is the first WAIT cycle with mem_stall=0

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If a request is present, pick the winner (see Configuration).
  - Register the winner's addr, wen (fetch forces 0) and wdata onto mem_*.
  - Go to WAIT_I or WAIT_D.
- WAIT_x:
  - mem_cen=1 only on the first WAIT cycle.
  - mem_addr, mem_wen and mem_wdata are held stable for the whole WAIT.
  - When mem_stall=0: on a read, capture mem_rdata into x_rdata; set x_ready; go to RESP.
  - A write leaves d_rdata unchanged.
- RESP: x_ready=1 for exactly this cycle, then go to IDLE. Requests are not sampled in RESP.
- Requester rule: after ready, a requester may drop req or present a new request in the next cycle. A new request is sampled in IDLE.
- Dropping req mid-transaction does not abort it. The transaction completes and ready still pulses.
- Outside WAIT_D, mem_wen=0. Outside WAIT, mem_addr and mem_wdata hold their last value.
- i_rdata and d_rdata hold their last captured value between transactions.
- Never more than one outstanding transaction. i_ready and d_ready are never high together.

## Timing
- Reset values:
  - state=IDLE.
  - mem_cen, mem_wen, i_ready, d_ready = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - Priority pointer = D.
- Reset mid-transaction: the transaction is abandoned immediately and all outputs return to reset values. No ready is issued for it.
- Latency: request sampled in IDLE at cycle t → mem_cen at t+1 → completion at t+1+S (S = cycles with mem_stall=1) → ready at t+2+S.
- Minimum request-to-ready latency is 2 cycles.
- Back-to-back throughput: one transaction per 3+S cycles.
- mem_stall is ignored outside WAIT states.

## Configuration
- ARB_RR_EN:
  - Undefined: fixed priority, D over I. A load/store of the current instruction always completes before the next fetch.
  - Defined: round-robin. A 1-bit pointer starts at D (reset value) and flips to the other requester each time a grant is made while both are requesting. A lone request is always granted.

## Test plan
- Lone fetch, mem_stall=0: i_req=1, i_addr=0x0000_0040, mem_rdata=0x1234_5678 → mem_cen pulse at t+1, i_ready at t+2 with i_rdata=0x1234_5678, mem_wen=0 throughout.
- Store with 3 stall cycles: d_req=1, d_wen=1, d_addr=0x100, d_wdata=0xDEAD_BEEF → mem_wen=1 and address/data stable for 4 WAIT cycles, d_ready at t+5, d_rdata unchanged.
- Simultaneous i_req and d_req held for 3 transactions:
  - Without ARB_RR_EN: grant order is D, D, D.
  - With ARB_RR_EN: grant order is D, I, D.
  - In both cases i_ready and d_ready are never high in the same cycle.
- Requester drops d_req during WAIT_D (load, 2 stalls) → d_ready still pulses once at t+4 with captured data; no extra transaction starts.
- rst_n low for one cycle during WAIT_I with mem_stall=1 → all outputs 0 asynchronously, no i_ready; a fresh i_req after release completes normally in 2 cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and shared-memory signals around mem_arbiter.
// slave is the arbiter's view; master is the core-plus-memory side driving it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_stall,
        output i_rdata, i_ready, d_rdata, d_ready, mem_cen, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_stall,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_cen, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise D always beats I.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, RESP} state_t;

    state_t            state, state_next;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic              iready_q, iready_d;
    logic              dready_q, dready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              grant_d;

`ifdef ARB_RR_EN
    // ptr_d_q = 1 means D wins the next contested grant
    logic ptr_d_q;

    always_comb grant_d = bus.d_req && (!bus.i_req || ptr_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_d_q <= 1'b1;
        else if (state == IDLE && bus.i_req && bus.d_req)
            ptr_d_q <= !ptr_d_q;
    end
`else
    always_comb grant_d = bus.d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cen_d      = 1'b0;
        wen_d      = wen_q;
        iready_d   = 1'b0;
        dready_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        irdata_d   = irdata_q;
        drdata_d   = drdata_q;
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    cen_d = 1'b1;
                    if (grant_d) begin
                        state_next = WAIT_D;
                        wen_d      = bus.d_wen;
                        addr_d     = bus.d_addr;
                        wdata_d    = bus.d_wdata;
                    end else begin
                        state_next = WAIT_I;
                        wen_d      = 1'b0;
                        addr_d     = bus.i_addr;
                    end
                end
            end
            WAIT_I: begin
                if (!bus.mem_stall) begin
                    irdata_d   = bus.mem_rdata;
                    iready_d   = 1'b1;
                    state_next = RESP;
                end
            end
            WAIT_D: begin
                if (!bus.mem_stall) begin
                    // stores leave the previous load data visible
                    if (!wen_q)
                        drdata_d = bus.mem_rdata;
                    wen_d      = 1'b0;
                    dready_d   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen_q    <= 1'b0;
            wen_q    <= 1'b0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            iready_q <= iready_d;
            dready_q <= dready_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign bus.mem_cen   = cen_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = irdata_q;
    assign bus.i_ready   = iready_q;
    assign bus.d_rdata   = drdata_q;
    assign bus.d_ready   = dready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model is compared every cycle,
// and literal expectations at key cycles pin both the model and the DUT.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   vec_count = 0;
    int   err_count = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd,
                                 input logic st, input logic [31:0] rd);
        bus.i_req     = ir;
        bus.i_addr    = ia;
        bus.d_req     = dr;
        bus.d_wen     = dw;
        bus.d_addr    = da;
        bus.d_wdata   = dd;
        bus.mem_stall = st;
        bus.mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    // Transaction model: a job starts in the cycle it is sampled, completes on the first
    // unstalled cycle after that, and its ready shows one cycle after completion.
    int          m_cyc, m_start, m_done, m_s, m_k;
    bit          m_active, m_owner_d, m_write;
`ifdef ARB_RR_EN
    bit          m_ptr_d;
`endif
    logic        e_cen, e_wen, e_iready, e_dready;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_start = 0; m_done = -1;
            m_active = 0; m_owner_d = 0; m_write = 0;
`ifdef ARB_RR_EN
            m_ptr_d = 1;
`endif
            e_cen = 0; e_wen = 0; e_iready = 0; e_dready = 0;
            e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
        end else begin
            m_s = m_cyc;
            m_cyc = m_cyc + 1;
            if (m_active && m_done < 0 && m_s >= m_start + 1 && !bus.mem_stall) begin
                m_done = m_s;
                if (!m_write) begin
                    if (m_owner_d) e_drdata = bus.mem_rdata;
                    else           e_irdata = bus.mem_rdata;
                end
            end
            if (m_active && m_done >= 0 && m_s == m_done + 1) begin
                m_active = 0;
            end else if (!m_active && (bus.i_req || bus.d_req)) begin
`ifdef ARB_RR_EN
                if (bus.i_req && bus.d_req) begin
                    m_owner_d = m_ptr_d;
                    m_ptr_d   = !m_ptr_d;
                end else begin
                    m_owner_d = bus.d_req;
                end
`else
                m_owner_d = bus.d_req;
`endif
                m_active = 1;
                m_start  = m_s;
                m_done   = -1;
                m_write  = m_owner_d && bus.d_wen;
                e_addr   = m_owner_d ? bus.d_addr : bus.i_addr;
                if (m_owner_d) e_wdata = bus.d_wdata;
            end
            m_k = m_cyc;
            e_cen    = m_active && (m_k == m_start + 1);
            e_wen    = m_active && m_write && (m_k >= m_start + 1) && (m_done < 0 || m_k <= m_done);
            e_iready = m_active && m_done >= 0 && (m_k == m_done + 1) && !m_owner_d;
            e_dready = m_active && m_done >= 0 && (m_k == m_done + 1) && m_owner_d;
        end
    end

    always @(negedge clk) begin
        checkOutput("mem_cen",   {31'b0, bus.mem_cen},   {31'b0, e_cen});
        checkOutput("mem_wen",   {31'b0, bus.mem_wen},   {31'b0, e_wen});
        checkOutput("mem_addr",  bus.mem_addr,           e_addr);
        checkOutput("mem_wdata", bus.mem_wdata,          e_wdata);
        checkOutput("i_ready",   {31'b0, bus.i_ready},   {31'b0, e_iready});
        checkOutput("d_ready",   {31'b0, bus.d_ready},   {31'b0, e_dready});
        checkOutput("i_rdata",   bus.i_rdata,            e_irdata);
        checkOutput("d_rdata",   bus.d_rdata,            e_drdata);
        checkOutput("ready_excl", {31'b0, bus.i_ready & bus.d_ready}, 32'd0);
    end

    logic [31:0] grants [3];
    logic [31:0] exp_grants [3];
    int          n_grants;

    initial begin
        rst_n = 1'b0;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_wen = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_stall = 0; bus.mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_cen",    {31'b0, bus.mem_cen}, 32'd0);
        checkOutput("reset_addr",   bus.mem_addr,         32'd0);
        checkOutput("reset_irdata", bus.i_rdata,          32'd0);
        checkOutput("reset_dready", {31'b0, bus.d_ready}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] lone fetch, no stall");
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 32'h1234_5678);
        checkOutput("fetch_cen",    {31'b0, bus.mem_cen}, 32'd1);
        checkOutput("fetch_wen",    {31'b0, bus.mem_wen}, 32'd0);
        checkOutput("fetch_addr",   bus.mem_addr,         32'h40);
        checkOutput("fetch_early",  {31'b0, bus.i_ready}, 32'd0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 32'h1234_5678);
        checkOutput("fetch_ready",  {31'b0, bus.i_ready}, 32'd1);
        checkOutput("fetch_rdata",  bus.i_rdata,          32'h1234_5678);
        checkOutput("fetch_cen_lo", {31'b0, bus.mem_cen}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch_pulse",  {31'b0, bus.i_ready}, 32'd0);

        $display("[TB] store with three stall cycles");
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 1, 0);
        checkOutput("st_cen",   {31'b0, bus.mem_cen}, 32'd1);
        checkOutput("st_wen",   {31'b0, bus.mem_wen}, 32'd1);
        checkOutput("st_addr",  bus.mem_addr,         32'h100);
        checkOutput("st_wdata", bus.mem_wdata,        32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 1, 0);
            checkOutput("st_wait_wen",  {31'b0, bus.mem_wen}, 32'd1);
            checkOutput("st_wait_addr", bus.mem_addr,         32'h100);
            checkOutput("st_wait_cen",  {31'b0, bus.mem_cen}, 32'd0);
            checkOutput("st_wait_rdy",  {31'b0, bus.d_ready}, 32'd0);
        end
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 32'h5555_5555);
        checkOutput("st_ready",   {31'b0, bus.d_ready}, 32'd1);
        checkOutput("st_rdata",   bus.d_rdata,          32'd0);
        checkOutput("st_wen_off", {31'b0, bus.mem_wen}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_pulse",   {31'b0, bus.d_ready}, 32'd0);

        $display("[TB] contention over three transactions");
        n_grants = 0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h1111_1111, 0, 32'hA000_0000 + k);
            if (bus.mem_cen && n_grants < 3) begin
                grants[n_grants] = bus.mem_addr;
                n_grants++;
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_RR_EN
        exp_grants[0] = 32'h300; exp_grants[1] = 32'h200; exp_grants[2] = 32'h300;
`else
        exp_grants[0] = 32'h300; exp_grants[1] = 32'h300; exp_grants[2] = 32'h300;
`endif
        checkOutput("grant_count", n_grants, 32'd3);
        for (int i = 0; i < 3; i++)
            checkOutput("grant_order", (i < n_grants) ? grants[i] : 32'hFFFF_FFFF, exp_grants[i]);

        $display("[TB] load with d_req dropped mid-wait");
        applyStimulus(0, 0, 1, 0, 32'h400, 0, 0, 0);
        checkOutput("ld_cen",  {31'b0, bus.mem_cen}, 32'd1);
        checkOutput("ld_addr", bus.mem_addr,         32'h400);
        applyStimulus(0, 0, 0, 0, 32'h400, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 32'h400, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 32'h400, 0, 0, 32'hCAFE_F00D);
        checkOutput("ld_ready", {31'b0, bus.d_ready}, 32'd1);
        checkOutput("ld_rdata", bus.d_rdata,          32'hCAFE_F00D);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("ld_no_extra", {31'b0, bus.mem_cen | bus.d_ready}, 32'd0);
        end

        $display("[TB] reset during stalled fetch");
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
        bus.mem_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cen",    {31'b0, bus.mem_cen}, 32'd0);
        checkOutput("rst_addr",   bus.mem_addr,         32'd0);
        checkOutput("rst_wdata",  bus.mem_wdata,        32'd0);
        checkOutput("rst_drdata", bus.d_rdata,          32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_iready", {31'b0, bus.i_ready}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 32'h600D_600D);
        checkOutput("post_cen",   {31'b0, bus.mem_cen}, 32'd1);
        checkOutput("post_addr",  bus.mem_addr,         32'h600);
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 32'h600D_600D);
        checkOutput("post_ready", {31'b0, bus.i_ready}, 32'd1);
        checkOutput("post_rdata", bus.i_rdata,          32'h600D_600D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_pulse", {31'b0, bus.i_ready}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
